snn_step_ctrl: RTL and testbench
================================

SNN_STEP_CTRL -- requirements
Module: snn_step_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset, both shared with the control-register block: synchronous, active-high reset.
REQ-002 The block SHALL have parameter CLK_FREQ_HZ, default 100000000, giving clock cycles per slow tick.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 65535, giving the net_done watchdog limit.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port cfg_word, input, 32 bits: control word from the AXI control register. Bit 0 is run, bit 3 is slow_en, bits 31:16 are num_steps.
REQ-007 The block SHALL have port net_done, input, 1 bit: the network has finished the current timestep.
REQ-008 The block SHALL have port net_rst, output, 1 bit: one-cycle network state clear.
REQ-009 The block SHALL have port step_en, output, 1 bit: one-cycle timestep launch.
REQ-010 The block SHALL have port busy, output, 1 bit: a run is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: the run completed.
REQ-012 The block SHALL have port err, output, 1 bit: watchdog expired.
REQ-013 The block SHALL have port step_cnt, output, 16 bits: timesteps completed.

Function
REQ-014 The FSM SHALL have states IDLE, CLEAR, WAIT_TICK, STEP, WAIT_NET and DONE, held in a registered state variable.
REQ-015 IDLE SHALL go to CLEAR on a rising edge of cfg_word[0], detected against a registered copy run_q. On the same edge it SHALL latch num_steps and slow_en and clear step_cnt and err.
REQ-016 CLEAR SHALL last exactly one cycle with net_rst=1. It SHALL then go to DONE if the latched num_steps=0, else to WAIT_TICK.
REQ-017 WAIT_TICK SHALL go to STEP on tick. tick is constant 1 when slow_en=0, so STEP follows WAIT_TICK by one cycle.
REQ-018 STEP SHALL last exactly one cycle with step_en=1, then go to WAIT_NET.
REQ-019 net_done SHALL be sampled only in WAIT_NET and ignored in all other states.
REQ-020 In WAIT_NET, net_done=1 SHALL increment step_cnt. The FSM SHALL then go to DONE if the new count equals num_steps, else to WAIT_TICK.
REQ-021 DONE SHALL assert done=1 and busy=0, and SHALL stay in DONE until cfg_word[0]=0, then go to IDLE.
REQ-022 busy SHALL be 1 in CLEAR, WAIT_TICK, STEP and WAIT_NET, and 0 elsewhere.
REQ-023 net_rst, step_en, busy and done SHALL be Moore decodes of the state register.
REQ-024 Abort: cfg_word[0]=0 in any busy state SHALL force IDLE on the next cycle. step_cnt SHALL hold, and done SHALL stay 0.
REQ-025 Abort SHALL take priority over a simultaneous net_done, which is then not counted.
REQ-026 Prescaler, slow mode: a counter of width clog2(CLK_FREQ_HZ) SHALL count 0..CLK_FREQ_HZ-1 and wrap. tick=1 when the counter equals CLK_FREQ_HZ-1.
REQ-027 The prescaler SHALL clear to 0 in CLEAR.
REQ-028 step_cnt SHALL be 16 bits unsigned, SHALL NOT exceed num_steps, and SHALL never wrap.
REQ-029 cfg_word changes mid-run, other than bit 0, SHALL have no effect.

Reset
REQ-030 rst=1 SHALL force IDLE on the next edge, from any state including mid-run.
REQ-031 Reset values SHALL be: state=IDLE, run_q=0, prescaler=0, step_cnt=0, err=0, and net_rst, step_en, busy, done all 0.
REQ-032 Because run_q resets to 0, run held at 1 through reset SHALL start a new run in the first cycle after reset releases.

Configuration
REQ-033 Macro SNN_STEP_TIMEOUT_EN SHALL control the watchdog.
REQ-034 With SNN_STEP_TIMEOUT_EN defined, a watchdog counter SHALL clear on entering WAIT_NET and increment each WAIT_NET cycle without net_done.
REQ-035 With SNN_STEP_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL set err=1 and go to DONE. err SHALL hold until the next run start or reset.
REQ-036 Without SNN_STEP_TIMEOUT_EN, there SHALL be no watchdog logic: err is tied 0 and WAIT_NET waits indefinitely.

Structure
REQ-037 Shared package snn_pkg SHALL hold the state encoding and the cfg_word bit positions (RUN_BIT=0, SLOW_BIT=3, NSTEP_LSB=16, NSTEP_MSB=31).
REQ-038 The prescaler SHALL be the sub-module tick_div, with inputs clk, rst, clr and en, and output tick.

Verification
REQ-039 Fast mode, num_steps=3, net_done 2 cycles after each step_en: SHALL give exactly 1 net_rst pulse, then 3 step_en pulses, with step_cnt=3, done=1 and busy=0.
REQ-040 num_steps=0: SHALL give CLEAR then DONE, zero step_en pulses, done=1 and step_cnt=0.
REQ-041 CLK_FREQ_HZ=10, slow_en=1, num_steps=2, net_done immediate: the step_en pulses SHALL be 10 cycles apart.
REQ-042 run dropped to 0 one cycle after the first net_done: SHALL give IDLE next cycle, busy=0, done=0 and step_cnt=1 held.
REQ-043 rst pulsed while in WAIT_NET with run held at 1: all outputs SHALL be 0 next cycle, then a new run starts with a net_rst pulse.
REQ-044 With SNN_STEP_TIMEOUT_EN and TIMEOUT_CYCLES=20, net_done never asserted: err=1 and done=1 SHALL appear 20 cycles after entering WAIT_NET, with step_cnt=0.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared definitions for the SNN timestep controller: FSM state encoding and
// the bit layout of the control word written through the AXI control register.
// Latency: n/a (package). Backpressure: n/a (package).
//
// Contents:
//   state_e        - controller FSM states
//   RUN_BIT        - cfg_word bit that starts (rising edge) or aborts (low) a run
//   SLOW_BIT       - cfg_word bit that selects prescaled (slow) timestep pacing
//   NSTEP_LSB/MSB  - cfg_word field holding the number of timesteps per run
//   state_is_busy  - states during which a run is considered in progress
package snn_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    WAIT_TICK = 3'd2,
    STEP      = 3'd3,
    WAIT_NET  = 3'd4,
    DONE      = 3'd5
  } state_e;

  localparam int RUN_BIT   = 0;
  localparam int SLOW_BIT  = 3;
  localparam int NSTEP_LSB = 16;
  localparam int NSTEP_MSB = 31;
  localparam int NSTEP_W   = NSTEP_MSB - NSTEP_LSB + 1;

  // DONE is deliberately not busy: software polls busy=0/done=1 for completion.
  function automatic logic state_is_busy(input state_e s);
    return (s == CLEAR) || (s == WAIT_TICK) || (s == STEP) || (s == WAIT_NET);
  endfunction

endpackage

// File: rtl/tick_div.sv
// Prescaler producing a one-cycle tick every CLK_FREQ_HZ cycles in slow mode.
// Latency: tick is a combinational decode of the counter register (0 cycles).
// Backpressure: none; free-running while en=1, tick is held high while en=0.
//
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset, counter to 0
//   clr  - synchronous clear, counter to 0 (takes priority over counting)
//   en   - slow mode enable; when low the counter holds and tick is constant 1
//   tick - pacing strobe for the step controller
module tick_div #(
  parameter int unsigned CLK_FREQ_HZ = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  // A divide-by-1 still needs a one-bit register to stay well formed.
  localparam int unsigned CNT_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_FREQ_HZ - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fast mode: every cycle is a tick, so WAIT_TICK lasts exactly one cycle.
  assign tick = en ? (cnt_q == CNT_LAST) : 1'b1;

endmodule

// File: rtl/snn_step_ctrl.sv
// Timestep sequencer for an SNN core: clears the network, then launches
// num_steps timesteps, each gated by a tick and completed by net_done.
// Latency: all outputs are Moore decodes of registered state; a run starts one
// cycle after the rising edge of run is seen; net_done is acted on next cycle.
// Backpressure: the network throttles via net_done; WAIT_NET stalls until it
// arrives (or the optional watchdog expires).
//
// Ports:
//   clk       - system clock, shared with the control-register block
//   rst       - synchronous active-high reset
//   cfg_word  - control word: [0] run, [3] slow_en, [31:16] num_steps
//   net_done  - network finished the current timestep (sampled in WAIT_NET only)
//   net_rst   - one-cycle network state clear at run start
//   step_en   - one-cycle timestep launch
//   busy      - run in progress (CLEAR/WAIT_TICK/STEP/WAIT_NET)
//   done      - run completed, held until run is dropped
//   err       - watchdog expired during the last run
//   step_cnt  - timesteps completed in the current/last run
//
// Build option: define SNN_STEP_TIMEOUT_EN to include the net_done watchdog
// (TIMEOUT_CYCLES, must be >= 1). Without it err is tied low and WAIT_NET
// waits indefinitely.
module snn_step_ctrl
  import snn_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 100000000,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cfg_word,
  input  logic        net_done,
  output logic        net_rst,
  output logic        step_en,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] step_cnt
);

  state_e               state_q, state_d;
  logic                 run_q, run_d;
  logic                 slow_q, slow_d;
  logic [NSTEP_W-1:0]   nsteps_q, nsteps_d;
  logic [15:0]          step_cnt_q, step_cnt_d;

  logic                 run;
  logic                 run_rise;
  logic                 tick;
  logic                 presc_clr;
  logic [15:0]          step_cnt_inc;

  assign run          = cfg_word[RUN_BIT];
  assign run_rise     = run & ~run_q;
  assign presc_clr    = (state_q == CLEAR);
  assign step_cnt_inc = step_cnt_q + 16'd1;

  // Only run, slow_en and num_steps are meaningful to this block.
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^{cfg_word[NSTEP_LSB-1:SLOW_BIT+1],
                             cfg_word[SLOW_BIT-1:RUN_BIT+1]};

  // slow_en is taken from the latched copy so mid-run cfg writes cannot
  // change the pacing of a run already in flight.
  tick_div #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ)
  ) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .en   (slow_q),
    .tick (tick)
  );

`ifdef SNN_STEP_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d    = state_q;
    run_d      = run;
    slow_d     = slow_q;
    nsteps_d   = nsteps_q;
    step_cnt_d = step_cnt_q;
`ifdef SNN_STEP_TIMEOUT_EN
    wd_d       = wd_q;
    err_d      = err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (run_rise) begin
          state_d    = CLEAR;
          slow_d     = cfg_word[SLOW_BIT];
          nsteps_d   = cfg_word[NSTEP_MSB:NSTEP_LSB];
          step_cnt_d = '0;
`ifdef SNN_STEP_TIMEOUT_EN
          err_d      = 1'b0;
`endif
        end
      end

      CLEAR: begin
        if (!run) begin
          state_d = IDLE;
        end else if (nsteps_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = WAIT_TICK;
        end
      end

      WAIT_TICK: begin
        if (!run) begin
          state_d = IDLE;
        end else if (tick) begin
          state_d = STEP;
        end
      end

      STEP: begin
        if (!run) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_NET;
`ifdef SNN_STEP_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end

      WAIT_NET: begin
        // Abort is checked first so a coincident net_done is not counted.
        if (!run) begin
          state_d = IDLE;
        end else if (net_done) begin
          step_cnt_d = step_cnt_inc;
          // Equality exit keeps step_cnt <= num_steps, so it can never wrap.
          if (step_cnt_inc == nsteps_q) begin
            state_d = DONE;
          end else begin
            state_d = WAIT_TICK;
          end
`ifdef SNN_STEP_TIMEOUT_EN
        end else if (wd_q == WD_LAST) begin
          // This cycle is the TIMEOUT_CYCLES-th one without net_done.
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
`endif
        end
      end

      DONE: begin
        if (!run) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      run_q      <= 1'b0;
      slow_q     <= 1'b0;
      nsteps_q   <= '0;
      step_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      slow_q     <= slow_d;
      nsteps_q   <= nsteps_d;
      step_cnt_q <= step_cnt_d;
    end
  end

`ifdef SNN_STEP_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign net_rst  = (state_q == CLEAR);
  assign step_en  = (state_q == STEP);
  assign busy     = state_is_busy(state_q);
  assign done     = (state_q == DONE);
  assign step_cnt = step_cnt_q;

endmodule

// File: tb/tb_snn_step_ctrl.sv
module tb_snn_step_ctrl;

  localparam int unsigned CLK_HZ = 10;
  localparam int unsigned TMO    = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_word;
  logic        net_done;
  logic        net_rst;
  logic        step_en;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] step_cnt;

  int checks   = 0;
  int failures = 0;

  // Pulse monitor, sampled on the falling edge.
  int cyc           = 0;
  int n_step        = 0;
  int n_rst         = 0;
  int last_step_cyc = 0;
  int prev_step_cyc = 0;
  int last_rst_cyc  = 0;

  always #5 clk = ~clk;

  snn_step_ctrl #(
    .CLK_FREQ_HZ    (CLK_HZ),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_word (cfg_word),
    .net_done (net_done),
    .net_rst  (net_rst),
    .step_en  (step_en),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .step_cnt (step_cnt)
  );

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (step_en === 1'b1) begin
      n_step        = n_step + 1;
      prev_step_cyc = last_step_cyc;
      last_step_cyc = cyc;
    end
    if (net_rst === 1'b1) begin
      n_rst        = n_rst + 1;
      last_rst_cyc = cyc;
    end
  end

  function automatic logic [31:0] mk_cfg(input logic run, input logic slow, input logic [15:0] n);
    return {n, 12'd0, slow, 2'b00, run};
  endfunction

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_step(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      if (step_en === 1'b1) ok = 1'b1;
      else adv();
    end
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      if (done === 1'b1) ok = 1'b1;
      else adv();
    end
  endtask

  task automatic stop_run();
    cfg_word = mk_cfg(1'b0, 1'b0, 16'd0);
    net_done = 1'b0;
    adv();
    adv();
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_word = '0; net_done = 1'b0;
    adv(); adv(); adv();
    checks++; if (net_rst !== 1'b0) begin failures++; $display("FAIL reset_net_rst got=%b exp=0", net_rst); end
    checks++; if (step_en !== 1'b0) begin failures++; $display("FAIL reset_step_en got=%b exp=0", step_en); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (step_cnt !== 16'd0) begin failures++; $display("FAIL reset_step_cnt got=%0d exp=0", step_cnt); end
    rst = 1'b0;
    adv(); adv();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_no_run_busy got=%b exp=0", busy); end
  endtask

  task automatic test_fast_three();
    int rst0, st0;
    bit ok;
    rst0 = n_rst; st0 = n_step;
    cfg_word = mk_cfg(1'b1, 1'b0, 16'd3);
    adv();
    checks++; if (net_rst !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL fast_clear net_rst=%b busy=%b exp=1,1", net_rst, busy); end
    for (int k = 0; k < 3; k++) begin
      wait_step(20, ok);
      checks++; if (!ok) begin failures++; $display("FAIL fast_step_wait step=%0d got=timeout exp=step_en", k); end
      adv(); adv();
      net_done = 1'b1;
      adv();
      net_done = 1'b0;
      checks++; if (step_cnt !== 16'(k + 1)) begin failures++; $display("FAIL fast_step_cnt got=%0d exp=%0d", step_cnt, k + 1); end
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL fast_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fast_busy got=%b exp=0", busy); end
    checks++; if (n_rst - rst0 !== 1) begin failures++; $display("FAIL fast_net_rst_pulses got=%0d exp=1", n_rst - rst0); end
    checks++; if (n_step - st0 !== 3) begin failures++; $display("FAIL fast_step_pulses got=%0d exp=3", n_step - st0); end
    adv(); adv();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL fast_done_hold got=%b exp=1", done); end
    cfg_word = mk_cfg(1'b0, 1'b0, 16'd3);
    adv();
    checks++; if (done !== 1'b0 || step_cnt !== 16'd3) begin failures++; $display("FAIL fast_to_idle done=%b cnt=%0d exp=0,3", done, step_cnt); end
    adv();
  endtask

  task automatic test_zero_steps();
    int st0;
    st0 = n_step;
    cfg_word = mk_cfg(1'b1, 1'b0, 16'd0);
    adv();
    checks++; if (net_rst !== 1'b1) begin failures++; $display("FAIL zero_clear got=%b exp=1", net_rst); end
    adv();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL zero_done done=%b busy=%b exp=1,0", done, busy); end
    checks++; if (step_cnt !== 16'd0) begin failures++; $display("FAIL zero_step_cnt got=%0d exp=0", step_cnt); end
    adv(); adv(); adv();
    checks++; if (n_step - st0 !== 0) begin failures++; $display("FAIL zero_step_pulses got=%0d exp=0", n_step - st0); end
    stop_run();
  endtask

  task automatic test_slow_mode();
    int st0;
    bit ok;
    st0 = n_step;
    net_done = 1'b1;   // held high, must be ignored outside WAIT_NET
    cfg_word = mk_cfg(1'b1, 1'b1, 16'd2);
    wait_step(40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL slow_step1_wait got=timeout exp=step_en"); end
    adv();
    wait_step(40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL slow_step2_wait got=timeout exp=step_en"); end
    wait_done(10, ok);
    checks++; if (!ok) begin failures++; $display("FAIL slow_done_wait got=timeout exp=done"); end
    checks++; if (prev_step_cyc - last_rst_cyc !== 11) begin failures++; $display("FAIL slow_first_step_delay got=%0d exp=11", prev_step_cyc - last_rst_cyc); end
    checks++; if (last_step_cyc - prev_step_cyc !== 10) begin failures++; $display("FAIL slow_step_spacing got=%0d exp=10", last_step_cyc - prev_step_cyc); end
    checks++; if (step_cnt !== 16'd2 || n_step - st0 !== 2) begin failures++; $display("FAIL slow_count cnt=%0d pulses=%0d exp=2,2", step_cnt, n_step - st0); end
    stop_run();
  endtask

  task automatic test_abort();
    bit ok;
    cfg_word = mk_cfg(1'b1, 1'b0, 16'd3);
    wait_step(20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL abort_step_wait got=timeout exp=step_en"); end
    adv(); adv();
    net_done = 1'b1;
    adv();
    net_done = 1'b0;
    cfg_word = mk_cfg(1'b0, 1'b0, 16'd3);
    adv();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_idle busy=%b done=%b exp=0,0", busy, done); end
    checks++; if (step_cnt !== 16'd1) begin failures++; $display("FAIL abort_step_cnt got=%0d exp=1", step_cnt); end
    adv(); adv(); adv();
    checks++; if (step_cnt !== 16'd1 || done !== 1'b0 || step_en !== 1'b0) begin failures++; $display("FAIL abort_hold cnt=%0d done=%b step_en=%b exp=1,0,0", step_cnt, done, step_en); end
  endtask

  task automatic test_abort_priority();
    bit ok;
    cfg_word = mk_cfg(1'b1, 1'b0, 16'd3);
    wait_step(20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL prio_step_wait got=timeout exp=step_en"); end
    adv();
    net_done = 1'b1;
    cfg_word = mk_cfg(1'b0, 1'b0, 16'd3);
    adv();
    net_done = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || step_cnt !== 16'd0) begin failures++; $display("FAIL prio_abort busy=%b done=%b cnt=%0d exp=0,0,0", busy, done, step_cnt); end
    adv();
  endtask

  task automatic test_cfg_change();
    bit ok;
    cfg_word = mk_cfg(1'b1, 1'b0, 16'd2);
    wait_step(20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL cfgchg_step1_wait got=timeout exp=step_en"); end
    cfg_word = mk_cfg(1'b1, 1'b1, 16'd1);
    adv(); adv();
    net_done = 1'b1;
    adv();
    net_done = 1'b0;
    checks++; if (step_cnt !== 16'd1 || busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL cfgchg_mid cnt=%0d busy=%b done=%b exp=1,1,0", step_cnt, busy, done); end
    wait_step(3, ok);
    checks++; if (!ok) begin failures++; $display("FAIL cfgchg_step2_fast got=timeout exp=step_en"); end
    adv(); adv();
    net_done = 1'b1;
    adv();
    net_done = 1'b0;
    checks++; if (step_cnt !== 16'd2 || done !== 1'b1) begin failures++; $display("FAIL cfgchg_end cnt=%0d done=%b exp=2,1", step_cnt, done); end
    stop_run();
  endtask

  task automatic test_rst_mid_run();
    bit ok;
    cfg_word = mk_cfg(1'b1, 1'b0, 16'd3);
    wait_step(20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_step_wait got=timeout exp=step_en"); end
    adv();
    rst = 1'b1;
    adv();
    checks++; if ({net_rst, step_en, busy, done, err} !== 5'b0 || step_cnt !== 16'd0) begin failures++; $display("FAIL rstmid_outputs flags=%b cnt=%0d exp=00000,0", {net_rst, step_en, busy, done, err}, step_cnt); end
    rst = 1'b0;
    adv();
    checks++; if (net_rst !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL rstmid_restart net_rst=%b busy=%b exp=1,1", net_rst, busy); end
    cfg_word = mk_cfg(1'b0, 1'b0, 16'd3);
    adv();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_abort_clear busy=%b exp=0", busy); end
    adv();
  endtask

  task automatic test_watchdog();
    bit ok;
    net_done = 1'b0;
    cfg_word = mk_cfg(1'b1, 1'b0, 16'd2);
    wait_step(20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wd_step_wait got=timeout exp=step_en"); end
`ifdef SNN_STEP_TIMEOUT_EN
    repeat (20) adv();
    checks++; if (done !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL wd_early done=%b busy=%b err=%b exp=0,1,0", done, busy, err); end
    adv();
    checks++; if (err !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL wd_expire err=%b done=%b busy=%b exp=1,1,0", err, done, busy); end
    checks++; if (step_cnt !== 16'd0) begin failures++; $display("FAIL wd_step_cnt got=%0d exp=0", step_cnt); end
    cfg_word = mk_cfg(1'b0, 1'b0, 16'd2);
    adv();
    checks++; if (err !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL wd_err_hold err=%b done=%b exp=1,0", err, done); end
    cfg_word = mk_cfg(1'b1, 1'b0, 16'd2);
    adv();
    checks++; if (err !== 1'b0 || net_rst !== 1'b1) begin failures++; $display("FAIL wd_err_clear err=%b net_rst=%b exp=0,1", err, net_rst); end
`else
    repeat (40) adv();
    checks++; if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0 || step_cnt !== 16'd0) begin failures++; $display("FAIL nowd_wait busy=%b done=%b err=%b cnt=%0d exp=1,0,0,0", busy, done, err, step_cnt); end
    net_done = 1'b1;
    adv();
    net_done = 1'b0;
    checks++; if (step_cnt !== 16'd1 || busy !== 1'b1) begin failures++; $display("FAIL nowd_late_done cnt=%0d busy=%b exp=1,1", step_cnt, busy); end
`endif
    stop_run();
  endtask

  initial begin
    rst = 1'b1;
    cfg_word = '0;
    net_done = 1'b0;
    test_reset();
    test_fast_three();
    test_zero_steps();
    test_slow_mode();
    test_abort();
    test_abort_priority();
    test_cfg_change();
    test_rst_mid_run();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
